// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the PISO serial transmitter.
package shift_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // Remaining-bit counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_piso_bit_counter.sv
// Loadable down-counter; flags the cycle on which its final count is consumed.
module bit_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          last
);

  logic [CW-1:0] cnt_r;

  // Count register: load wins over decrement, and zero is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = en && (cnt_r == CW'(1'b1));

endmodule

// File: rtl/shift_piso.sv
// Parallel-in serial-out transmitter: MSB first, gapless back-to-back words.
module shift_piso
  import shift_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pdata,
  input  logic             shift_en,
  output logic             so,
  output logic             so_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH);

  // The full shift register is {so_r, sreg_r}: its MSB doubles as the output flop.
  state_t           state_r;
  logic [WIDTH-2:0] sreg_r;
  logic             so_r;
  logic             cnt_en_s;
  logic             last_s;
  logic             hs_s;

  // Handshake and end-of-word decode.
  always_comb begin
    cnt_en_s   = (state_r == ST_SHIFT) && shift_en;
    load_ready = !rst && ((state_r == ST_IDLE) || last_s);
    hs_s       = load_valid && load_ready;
  end

  bit_counter #(
    .CW(CW)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (hs_s),
    .load_val (LOAD_CNT),
    .en       (cnt_en_s),
    .last     (last_s)
  );

  // FSM, shift register and serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sreg_r  <= {(WIDTH-1){1'b0}};
      so_r    <= 1'b0;
    end else if (hs_s) begin
      state_r <= ST_SHIFT;
      sreg_r  <= pdata[WIDTH-2:0];
      so_r    <= pdata[WIDTH-1];
    end else begin
      case (state_r)
        ST_SHIFT: begin
          if (shift_en) begin
            so_r   <= sreg_r[WIDTH-2];
            sreg_r <= sreg_r << 1'b1;
            if (last_s) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= state_r;
        end
      endcase
    end
  end

  assign so       = so_r;
  assign so_valid = (state_r == ST_SHIFT);
  assign busy     = (state_r == ST_SHIFT);
  assign done     = last_s;

endmodule

// File: tb/tb_shift_piso.sv
// Directed vector table plus randomized loopback against a queue-based reference model.
module tb_shift_piso;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst, load_valid, load_ready, shift_en, so, so_valid, done, busy;
  logic [W-1:0] pdata;

  always #5 clk = ~clk;

  shift_piso #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .pdata(pdata), .shift_en(shift_en), .so(so), .so_valid(so_valid),
    .done(done), .busy(busy)
  );

  // exp packs {so, so_valid, done, load_ready, busy}
  typedef struct {
    string        name;
    logic         r;
    logic         lv;
    logic [W-1:0] pd;
    logic         sh;
    logic [4:0]   exp;
  } vec_t;

  vec_t         tbl[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic         mq[$];       // bits of the word in flight, head = bit on so
  logic [W-1:0] wq[$];       // words accepted but not yet finished
  logic [W-1:0] rx;
  int           words_done = 0;

  function automatic void add(input string nm, input logic r, input logic lv,
                              input logic [W-1:0] pd, input logic sh, input logic [4:0] e);
    vec_t v;
    v.name = nm; v.r = r; v.lv = lv; v.pd = pd; v.sh = sh; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic logic [4:0] model_out(input logic r, input logic sh);
    logic live, lst;
    live = (mq.size() > 0);
    lst  = (mq.size() == 1) && sh;
    return {live ? mq[0] : 1'b0, live, lst, !r && (!live || lst), live};
  endfunction

  task automatic model_edge(input logic r, input logic lv, input logic [W-1:0] pd, input logic sh);
    logic [4:0] o;
    o = model_out(r, sh);
    if (r) begin
      mq.delete();
    end else begin
      if (sh && mq.size() > 0) void'(mq.pop_front());
      if (lv && o[1]) begin
        for (int i = W - 1; i >= 0; i--) mq.push_back(pd[i]);
      end
    end
  endtask

  task automatic apply(input logic r, input logic lv, input logic [W-1:0] pd, input logic sh);
    @(negedge clk);
    rst = r; load_valid = lv; pdata = pd; shift_en = sh;
    #1;
  endtask

  task automatic check(input string nm, input logic [4:0] want);
    logic [4:0] got;
    got = {so, so_valid, done, load_ready, busy};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: so,so_valid,done,load_ready,busy = %b, expected %b", nm, got, want);
    end
  endtask

  initial begin
    logic         r, lv, sh;
    logic [W-1:0] pd, expw;
    logic [4:0]   want;

    // single word after reset
    add("A rst",        1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000);
    add("A idle",       1'b0, 1'b1, 5'b10110, 1'b1, 5'b00010);
    add("A bit0",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("A bit1",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("A bit2",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("A bit3",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("A bit4 done",  1'b0, 1'b0, 5'b00000, 1'b1, 5'b01111);
    add("A idle after", 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00010);
    // back-to-back with load_valid held while busy
    add("B load1",      1'b0, 1'b1, 5'b11001, 1'b1, 5'b00010);
    add("B w1 bit0",    1'b0, 1'b1, 5'b00111, 1'b1, 5'b11001);
    add("B w1 bit1",    1'b0, 1'b1, 5'b00111, 1'b1, 5'b11001);
    add("B w1 bit2",    1'b0, 1'b1, 5'b00111, 1'b1, 5'b01001);
    add("B w1 bit3",    1'b0, 1'b1, 5'b00111, 1'b1, 5'b01001);
    add("B w1 last",    1'b0, 1'b1, 5'b00111, 1'b1, 5'b11111);
    add("B w2 bit0",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("B w2 bit1",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("B w2 bit2",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("B w2 bit3",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("B w2 last",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b11111);
    add("B idle",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b00010);
    // stall on bit 2 with pdata churning
    add("C load",       1'b0, 1'b1, 5'b10000, 1'b1, 5'b00010);
    add("C bit0",       1'b0, 1'b0, 5'b11111, 1'b1, 5'b11001);
    add("C stall1",     1'b0, 1'b0, 5'b11111, 1'b0, 5'b01001);
    add("C stall2",     1'b0, 1'b1, 5'b11111, 1'b0, 5'b01001);
    add("C stall3",     1'b0, 1'b0, 5'b01011, 1'b0, 5'b01001);
    add("C bit1 go",    1'b0, 1'b0, 5'b11111, 1'b1, 5'b01001);
    add("C bit2",       1'b0, 1'b0, 5'b11111, 1'b1, 5'b01001);
    add("C bit3",       1'b0, 1'b0, 5'b11111, 1'b1, 5'b01001);
    add("C last",       1'b0, 1'b0, 5'b11111, 1'b1, 5'b01111);
    add("C idle",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b00010);
    // reset mid-word, then a clean word
    add("D load",       1'b0, 1'b1, 5'b11111, 1'b1, 5'b00010);
    add("D bit0",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("D bit1",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("D bit2",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("D rst",        1'b1, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("D reload",     1'b0, 1'b1, 5'b01010, 1'b1, 5'b00010);
    add("D w bit0",     1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("D w bit1",     1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("D w bit2",     1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("D w bit3",     1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("D w last",     1'b0, 1'b0, 5'b00000, 1'b1, 5'b01111);
    add("D idle",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b00010);
    // idle load with shift_en low, stall on the last bit, chained load
    add("E load sh0",   1'b0, 1'b1, 5'b10101, 1'b0, 5'b00010);
    add("E hold0",      1'b0, 1'b0, 5'b00000, 1'b0, 5'b11001);
    add("E bit0",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("E bit1",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("E bit2",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("E bit3",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("E last stall", 1'b0, 1'b1, 5'b11111, 1'b0, 5'b11001);
    add("E last go",    1'b0, 1'b1, 5'b00011, 1'b1, 5'b11111);
    add("E w2 bit0",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("E w2 bit1",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("E w2 bit2",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b01001);
    add("E w2 bit3",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b11001);
    add("E w2 last",    1'b0, 1'b0, 5'b00000, 1'b1, 5'b11111);
    add("E idle",       1'b0, 1'b0, 5'b00000, 1'b1, 5'b00010);

    apply(1'b1, 1'b0, 5'b00000, 1'b1);
    model_edge(1'b1, 1'b0, 5'b00000, 1'b1);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].lv, tbl[i].pd, tbl[i].sh);
      check(tbl[i].name, tbl[i].exp);
      model_edge(tbl[i].r, tbl[i].lv, tbl[i].pd, tbl[i].sh);
    end

    // random traffic with a left-shift receiver on the serial line
    rx = '0;
    for (int cyc = 0; cyc < 6000 && words_done < 100; cyc++) begin
      r  = ($urandom_range(0, 199) == 0);
      lv = ($urandom_range(0, 1) == 1);
      pd = W'($urandom);
      sh = ($urandom_range(0, 3) != 0);
      apply(r, lv, pd, sh);
      want = model_out(r, sh);
      check("random", want);
      if (r) begin
        wq.delete();
        rx = '0;
      end else begin
        if (so_valid && shift_en) rx = {rx[W-2:0], so};
        if (want[2]) begin
          vectors++;
          if (wq.size() == 0) begin
            miscompares++;
            $display("FAIL loopback: receiver holds %b, no word was expected", rx);
          end else begin
            expw = wq.pop_front();
            if (rx !== expw) begin
              miscompares++;
              $display("FAIL loopback: receiver holds %b, expected %b", rx, expw);
            end
            words_done++;
          end
        end
        if (lv && want[1]) wq.push_back(pd);
      end
      model_edge(r, lv, pd, sh);
    end

    vectors++;
    if (words_done < 100) begin
      miscompares++;
      $display("FAIL word budget: %0d words completed, expected 100", words_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
